// File: rtl/mat_result_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mat_result_streamer_pkg
// Purpose  : Shared defaults, FP16 constants and FSM encodings for the result
//            streamer and the matrix-multiply control unit.
// Revision : 1.0 - initial release
// ============================================================================
package mat_result_streamer_pkg;

    localparam int DEF_W = 16;
    localparam int DEF_N = 3;

    localparam logic [15:0] FP16_ONE  = 16'h3c00;
    localparam logic [15:0] FP16_ZERO = 16'h0000;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Index fields keep at least one bit so N=1 still has a legal vector.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mat_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : mat_result_streamer_if
// Purpose  : Valid/ready element stream carrying data, indices and last flag.
// Revision : 1.0 - initial release
// ============================================================================
interface mat_result_streamer_if #(
    parameter int W = 16,
    parameter int N = 3
);
    import mat_result_streamer_pkg::*;

    localparam int RW = clog2_min1(N);

    logic [W-1:0]  data;
    logic          valid;
    logic          ready;
    logic          last;
    logic [RW-1:0] row;
    logic [RW-1:0] col;

    modport master (output data, valid, last, row, col, input ready);
    modport slave  (input data, valid, last, row, col, output ready);

endinterface
`default_nettype wire

// File: rtl/mat_result_streamer_flat_elem_mux.sv
`default_nettype none
// ============================================================================
// Module   : mat_result_streamer_flat_elem_mux
// Purpose  : Combinational select of element k from an MSB-first flat matrix.
// Revision : 1.0 - initial release
// ============================================================================
module mat_result_streamer_flat_elem_mux
    import mat_result_streamer_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N,
    parameter int KW = clog2_min1(N*N)
)(
    input  wire logic [W*N*N-1:0] i_flat,
    input  wire logic [KW-1:0]    i_k,
    output      logic [W-1:0]     o_elem
);

    localparam int c_ne = N*N;

    // Element 0 sits in the top W bits of the bus.
    always_comb begin
        o_elem = '0;
        for (int i = 0; i < c_ne; i++) begin
            if (i_k == KW'(i)) begin
                o_elem = i_flat[W*c_ne-1-i*W -: W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mat_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : mat_result_streamer
// Purpose  : Captures the N x N result matrix on a done edge and drains it
//            row-major, one element per beat, over a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module mat_result_streamer
    import mat_result_streamer_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
)(
    input  wire logic                 i_clk,
    input  wire logic                 i_rst,
    input  wire logic                 i_done,
    input  wire logic [W*N*N-1:0]     i_C,
    mat_result_streamer_if.master     m_stream,
    output      logic                 o_busy,
    output      logic                 o_overrun,
    input  wire logic                 i_clr_overrun
);

    localparam int c_ne = N*N;
    localparam int KW   = clog2_min1(c_ne);
    localparam int RW   = clog2_min1(N);

    localparam logic [KW-1:0] c_last_k   = KW'(c_ne-1);
    localparam logic [RW-1:0] c_last_col = RW'(N-1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [KW-1:0]    r_k;
    logic [RW-1:0]    r_row;
    logic [RW-1:0]    r_col;
    logic [W*c_ne-1:0] r_buf;
    logic             r_done_q;
    logic             r_overrun;

    logic             w_edge;
    logic             w_hs;
    logic             w_final;
    logic             w_capture;
    logic             w_drop;
    logic             w_advance;
    logic [W-1:0]     w_elem;

    assign w_edge    = i_done && !r_done_q;
    assign w_hs      = (r_state == ST_STREAM) && m_stream.ready;
    assign w_final   = w_hs && (r_k == c_last_k);
    // An edge landing on the final handshake reloads without a bubble.
    assign w_capture = w_edge && ((r_state == ST_IDLE) || w_final);
    assign w_drop    = w_edge && (r_state == ST_STREAM) && !w_final;
    assign w_advance = w_hs && !w_final;

    mat_result_streamer_flat_elem_mux #(
        .W  (W),
        .N  (N),
        .KW (KW)
    ) u_mux (
        .i_flat (r_buf),
        .i_k    (r_k),
        .o_elem (w_elem)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_final && !w_capture) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_stream.valid = 1'b0;
        m_stream.data  = '0;
        m_stream.row   = '0;
        m_stream.col   = '0;
        m_stream.last  = 1'b0;
        o_busy         = 1'b0;
        if (r_state == ST_STREAM) begin
            m_stream.valid = 1'b1;
            m_stream.data  = w_elem;
            m_stream.row   = r_row;
            m_stream.col   = r_col;
            m_stream.last  = (r_k == c_last_k);
            o_busy         = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_k       <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_buf     <= '0;
            r_done_q  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done_q <= i_done;
            if (w_capture) begin
                r_buf <= i_C;
                r_k   <= '0;
                r_row <= '0;
                r_col <= '0;
            end else if (w_advance) begin
                r_k <= r_k + 1'b1;
                if (r_col == c_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mat_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat_result_streamer
// Purpose  : Directed and random stimulus against a queue-based beat model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat_result_streamer;

    localparam int W  = 16;
    localparam int N  = 3;
    localparam int NE = N*N;

    typedef struct {
        logic [W-1:0] d;
        int           row;
        int           col;
        logic         last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_done;
    logic [W*NE-1:0]   i_C;
    logic              o_busy;
    logic              o_overrun;
    logic              i_clr_overrun;
    logic [W-1:0]      mat [NE];

    int                checks = 0;
    int                errors = 0;

    beat_t             q[$];
    logic              m_prev;
    logic              m_ovr;

    mat_result_streamer_if #(.W(W), .N(N)) sif ();

    mat_result_streamer #(.W(W), .N(N)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_done        (i_done),
        .i_C           (i_C),
        .m_stream      (sif),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun),
        .i_clr_overrun (i_clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pack_mat();
        for (int i = 0; i < NE; i++) i_C[W*NE-1-i*W -: W] = mat[i];
    endtask

    task automatic push_matrix();
        beat_t b;
        for (int i = 0; i < NE; i++) begin
            b.d    = mat[i];
            b.row  = i / N;
            b.col  = i % N;
            b.last = (i == NE-1);
            q.push_back(b);
        end
    endtask

    // One clock: check current outputs, advance the model, then the DUT.
    task automatic step(input logic d, input logic r, input logic c);
        logic hs, edge_seen;
        i_done        = d;
        sif.ready     = r;
        i_clr_overrun = c;
        pack_mat();
        chk("valid", 32'(sif.valid), 32'(q.size() != 0));
        chk("busy",  32'(o_busy),    32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("data", 32'(sif.data), 32'(q[0].d));
            chk("row",  32'(sif.row),  32'(q[0].row));
            chk("col",  32'(sif.col),  32'(q[0].col));
            chk("last", 32'(sif.last), 32'(q[0].last));
        end
        hs        = (q.size() != 0) && r;
        edge_seen = d && !m_prev;
        m_prev    = d;
        if (hs) void'(q.pop_front());
        if (edge_seen && q.size() == 0) begin
            push_matrix();
            if (c) m_ovr = 1'b0;
        end else if (edge_seen) begin
            m_ovr = 1'b1;
        end else if (c) begin
            m_ovr = 1'b0;
        end
        @(posedge clk); #1;
        chk("overrun", 32'(o_overrun), 32'(m_ovr));
    endtask

    task automatic do_reset(input logic d);
        rst = 1'b1; i_done = d; sif.ready = 1'b0; i_clr_overrun = 1'b0;
        @(posedge clk); #1;
        q.delete(); m_prev = 1'b0; m_ovr = 1'b0;
        chk("rst_valid",   32'(sif.valid), 32'd0);
        chk("rst_busy",    32'(o_busy),    32'd0);
        chk("rst_overrun", 32'(o_overrun), 32'd0);
        chk("rst_data",    32'(sif.data),  32'd0);
        chk("rst_rowcol",  32'({sif.row, sif.col}), 32'd0);
        chk("rst_last",    32'(sif.last),  32'd0);
        rst = 1'b0;
    endtask

    task automatic fill_seq(input logic [W-1:0] base);
        for (int i = 0; i < NE; i++) mat[i] = base + W'(i + 1);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NE; i++) mat[i] = W'($urandom);
    endtask

    initial begin
        logic [11:0] rdy_pat;
        rdy_pat = 12'b1001_0111_0111;
        for (int i = 0; i < NE; i++) mat[i] = '0;
        pack_mat();
        do_reset(1'b0);

        // Uniform 3.0 matrix, free-flowing consumer.
        for (int i = 0; i < NE; i++) mat[i] = 16'h4200;
        step(1, 1, 0);
        for (int i = 0; i < NE + 2; i++) step(0, 1, 0);

        // Ordered data to check row-major indexing.
        fill_seq(16'h0000);
        step(1, 1, 0);
        for (int i = 0; i < NE + 2; i++) step(0, 1, 0);

        // Backpressure pattern 1,0,0,1,0,1,1,1,0,1,1,1 then drain.
        step(1, 1, 0);
        for (int i = 11; i >= 0; i--) step(0, rdy_pat[i], 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0);

        // Second edge mid-stream is dropped and flags overrun.
        step(1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        fill_seq(16'h0050);
        step(1, 1, 0);
        fill_seq(16'h0000);
        for (int i = 0; i < NE; i++) step(0, 1, 0);
        chk("overrun_sticky", 32'(o_overrun), 32'd1);
        step(0, 1, 1);
        chk("overrun_cleared", 32'(o_overrun), 32'd0);

        // Edge coincident with the final handshake reloads with no gap.
        step(1, 1, 0);
        for (int i = 0; i < NE - 1; i++) step(0, 1, 0);
        fill_seq(16'h00A0);
        step(1, 1, 0);
        chk("b2b_valid", 32'(sif.valid), 32'd1);
        chk("b2b_data",  32'(sif.data),  32'h00A1);
        chk("b2b_ovr",   32'(o_overrun), 32'd0);
        for (int i = 0; i < NE + 1; i++) step(0, 1, 0);

        // Reset during beat 5 with done held high through release.
        fill_rand();
        step(1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        do_reset(1'b1);
        fill_rand();
        for (int i = 0; i < NE + 3; i++) step(1, 1, 0);
        chk("post_rst_ovr", 32'(o_overrun), 32'd0);

        // Random traffic: sparse done pulses, random ready and clear.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) fill_rand();
            step(($urandom_range(0, 9) == 0), $urandom_range(0, 2) != 0,
                 ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 3 * NE; i++) step(0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
